fpcvt_pipe: RTL and testbench
=============================

Name: fpcvt_pipe

Overview:
- Parametrised, 3-stage pipelined two's-complement to mini-float converter with valid/ready streaming handshake.
- Output encodes value = (-1)^s · F · 2^E, where F is an unsigned MAN_W-bit significand and E is an EXP_W-bit exponent.
- Per-sample selectable rounding: half-up on magnitude, or truncate.
- Per-sample saturation flag, plus a saturating event counter.
- Sits between the fixed-point sample source and float consumers; defaults reproduce the existing 12-bit to 8-bit (s,3,4) format.

Parameters:
- IN_W, 12, input width, two's complement.
- EXP_W, 3, exponent width; E_MAX = 2^EXP_W - 1.
- MAN_W, 4, significand width. Elaboration-time error unless IN_W-1 <= MAN_W + E_MAX.
- CNT_W, 16, saturation counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts the sample this cycle.
- in_data  in  IN_W  two's-complement sample.
- rnd_mode  in  1  0 = round half-up on magnitude, 1 = truncate; sampled with in_data.
- out_valid  out  1  output valid.
- out_ready  in  1  consumer accepts.
- out_sign  out  1  sign.
- out_exp  out  EXP_W  exponent E.
- out_man  out  MAN_W  significand F.
- out_sat  out  1  this result saturated.
- sat_clr  in  1  clears sat_count.
- sat_count  out  CNT_W  count of transferred saturated results.

Behaviour:
- Reset: all stage valids = 0; out_valid = 0; out_sign/out_exp/out_man/out_sat = 0; sat_count = 0. Reset mid-stream discards all in-flight samples; out_valid is 0 the cycle after rst is sampled high.
- Pipeline enable: adv = !out_valid || out_ready. in_ready = adv (combinational, no skid). All stages shift together when adv = 1; all hold when adv = 0.
- Latency: 3 cycles from accepted input to out_valid with no stall. Throughput: 1 sample/cycle.
- Bubbles propagate as invalid stages; no reordering.
- S1 (capture):
  - s = in_data[IN_W-1].
  - M = |in_data| as an unsigned IN_W-bit value, so -2^(IN_W-1) gives M = 2^(IN_W-1).
  - Latch rnd_mode.
- S2 (normalise):
  - p = index of the highest set bit of M (via the leading-one detector).
  - M = 0: E = 0, F = 0, R = 0.
  - p < MAN_W: E = 0, F = M[MAN_W-1:0], R = 0.
  - Otherwise: E = p-MAN_W+1, F = M[p:p-MAN_W+1], R = M[p-MAN_W].
  - M >= 2^(MAN_W+E_MAX): set presat.
- S3 (round and saturate), carrying an EXP_W+1-bit exponent internally:
  - If rnd_mode = 0 and R = 1: F = F+1.
  - If F overflows to 2^MAN_W: F = 2^(MAN_W-1), E = E+1.
  - If presat or E > E_MAX: E = E_MAX, F = all ones, out_sat = 1.
  - Sign is unaffected by saturation. Zero input gives s = 0, E = 0, F = 0.
  - No sticky/round-to-even logic.
- Outputs are registered from S3 and held stable while out_valid && !out_ready.
- sat_count:
  - Increments on out_valid && out_ready && out_sat.
  - Sticks at all ones.
  - sat_clr has priority over a simultaneous increment (result 0).
  - Independent of adv.

Decomposition:
- Package fpcvt_pkg holds:
  - localparam function for E_MAX;
  - rounding-mode constants RND_HALF_UP = 0 and RND_TRUNC = 1;
  - a packed struct {sign, exp, man, sat} typedef parameterised by fixed default widths, used by consumers.
- One sub-module, fpcvt_lzc: parametrised leading-one position encoder.
  - Inputs: IN_W-bit vector.
  - Outputs: index and a zero flag.
  - Instantiated in S2.

Test Plan:
- Defaults, rnd_mode = 0, inputs 44, 45, 46, 47 back-to-back, out_ready = 1 -> outputs (s,E,F) = (0,2,11), (0,2,11), (0,2,12), (0,2,12) on cycles 3-6; out_sat = 0.
- Inputs 31, 13, 0, -47 with rnd_mode = 0 -> (0,2,8), (0,0,13), (0,0,0), (1,2,12).
- Input 47 with rnd_mode = 1 -> (0,2,11).
- Inputs -2048 and 2047 with rnd_mode = 0 -> (1,7,15) sat = 1 and (0,7,15) sat = 1; sat_count = 2.
- Then 2047 with rnd_mode = 1 -> (0,7,15), sat = 0.
- Backpressure: 6 inputs streamed, out_ready held 0 for 5 cycles from first out_valid:
  - in_ready drops once 3 samples are in flight;
  - outputs stay stable while stalled;
  - all 6 results arrive in order, none lost or duplicated.
- Assert rst while 3 samples are in flight -> out_valid = 0 next cycle, sat_count = 0.
- sat_clr asserted the same cycle as a saturated transfer -> sat_count = 0.
- Counter wrap check with CNT_W = 2: 5 saturated transfers -> sat_count holds at 3.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// Shared types and constants for the two's-complement to mini-float converter.
// Latency n/a (declarations only); backpressure n/a.
package fpcvt_pkg;

  function automatic int e_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  localparam logic RND_HALF_UP = 1'b0;
  localparam logic RND_TRUNC   = 1'b1;

  localparam int DEF_EXP_W = 3;
  localparam int DEF_MAN_W = 4;
  localparam int DEF_E_MAX = e_max(DEF_EXP_W);

  // Result word as seen by float consumers of the default (s,3,4) format.
  typedef struct packed {
    logic                 sign;
    logic [DEF_EXP_W-1:0] exp;
    logic [DEF_MAN_W-1:0] man;
    logic                 sat;
  } fp_t;

endpackage

// File: rtl/fpcvt_if.sv
// Sample-in / float-out stream bundle; slave is the converter, master the environment.
// Latency n/a; backpressure via in_ready/out_ready.
interface fpcvt_if #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             rnd_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_man;
  logic             out_sat;
  logic             sat_clr;
  logic [CNT_W-1:0] sat_count;

  modport slave (
    input  in_valid, in_data, rnd_mode, out_ready, sat_clr,
    output in_ready, out_valid, out_sign, out_exp, out_man, out_sat, sat_count
  );

  modport master (
    output in_valid, in_data, rnd_mode, out_ready, sat_clr,
    input  in_ready, out_valid, out_sign, out_exp, out_man, out_sat, sat_count
  );

endinterface

// File: rtl/fpcvt_lzc.sv
// Leading-one position encoder: index of the highest set bit, plus an all-zero flag.
// Purely combinational, no backpressure.
module fpcvt_lzc #(
  parameter int W     = 12,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o
);

  // Ascending scan: the last hit is the most significant one.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign zero_o = ~|vec_i;

endmodule

// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: two's-complement to (s,E,F) mini-float, 3 register stages, 1 sample/cycle.
// Whole pipe stalls together on out_valid && !out_ready; in_ready = adv (no skid).
module fpcvt_pipe #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int CNT_W = 16
) (
  input logic    clk,
  input logic    rst,
  fpcvt_if.slave io
);

  import fpcvt_pkg::*;

  localparam int E_MAX = e_max(EXP_W);
  localparam int IDX_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  if (IN_W - 1 > MAN_W + E_MAX) begin : g_cfg_err
    $error("fpcvt_pipe: IN_W-1 must not exceed MAN_W + 2^EXP_W - 1");
  end

  logic adv;

  logic            s1_vld_q, s1_vld_d;
  logic            s1_sign_q, s1_sign_d;
  logic [IN_W-1:0] s1_mag_q, s1_mag_d;
  logic            s1_rnd_q, s1_rnd_d;

  logic             s2_vld_q, s2_vld_d;
  logic             s2_sign_q, s2_sign_d;
  logic             s2_rnd_q, s2_rnd_d;
  logic [EXP_W:0]   s2_exp_q, s2_exp_d;
  logic [MAN_W-1:0] s2_man_q, s2_man_d;
  logic             s2_rbit_q, s2_rbit_d;
  logic             s2_presat_q, s2_presat_d;

  logic             out_valid_q, out_valid_d;
  logic             out_sign_q, out_sign_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic [MAN_W-1:0] out_man_q, out_man_d;
  logic             out_sat_q, out_sat_d;

  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  logic [IDX_W-1:0] lzc_idx;
  logic             lzc_zero;

  assign adv         = !out_valid_q || io.out_ready;
  assign io.in_ready = adv;

  // S1: sign/magnitude capture; -2^(IN_W-1) negates onto itself, read as unsigned.
  always_comb begin
    s1_vld_d  = io.in_valid;
    s1_sign_d = io.in_data[IN_W-1];
    s1_mag_d  = io.in_data[IN_W-1] ? -io.in_data : io.in_data;
    s1_rnd_d  = io.rnd_mode;
  end

  fpcvt_lzc #(
    .W     (IN_W),
    .IDX_W (IDX_W)
  ) u_lzc (
    .vec_i  (s1_mag_q),
    .idx_o  (lzc_idx),
    .zero_o (lzc_zero)
  );

  // S2: keep MAN_W bits below and including the leading one, plus the next bit down.
  always_comb begin
    int p;
    int sh;
    p           = int'(lzc_idx);
    sh          = p - MAN_W;
    s2_vld_d    = s1_vld_q;
    s2_sign_d   = s1_sign_q;
    s2_rnd_d    = s1_rnd_q;
    s2_exp_d    = '0;
    s2_man_d    = '0;
    s2_rbit_d   = 1'b0;
    s2_presat_d = 1'b0;
    if (!lzc_zero) begin
      if (p < MAN_W) begin
        s2_man_d = MAN_W'(s1_mag_q);
      end else begin
        s2_man_d  = MAN_W'(s1_mag_q >> (sh + 1));
        s2_rbit_d = |(s1_mag_q & (IN_W'(1) << sh));
        s2_exp_d  = (EXP_W+1)'(sh + 1);
      end
      s2_presat_d = (p >= MAN_W + E_MAX);
    end
  end

  // S3: exponent carries one extra bit so a rounding carry past E_MAX is visible.
  always_comb begin
    logic [MAN_W:0] f_inc;
    logic [MAN_W-1:0] f_r;
    logic [EXP_W:0] e_r;
    logic           rnd_up;
    rnd_up = (s2_rnd_q == RND_HALF_UP) && s2_rbit_q;
    f_inc  = {1'b0, s2_man_q} + {{MAN_W{1'b0}}, rnd_up};
    f_r    = f_inc[MAN_W-1:0];
    e_r    = s2_exp_q;
    if (f_inc[MAN_W]) begin
      f_r = MAN_W'(1) << (MAN_W - 1);
      e_r = s2_exp_q + (EXP_W+1)'(1);
    end
    out_valid_d = s2_vld_q;
    out_sign_d  = s2_sign_q;
    out_sat_d   = s2_presat_q || (e_r > (EXP_W+1)'(E_MAX));
    out_exp_d   = out_sat_d ? EXP_W'(E_MAX) : e_r[EXP_W-1:0];
    out_man_d   = out_sat_d ? {MAN_W{1'b1}} : f_r;
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (io.sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_valid_q && io.out_ready && out_sat_q && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_rnd_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_rnd_q    <= 1'b0;
      s2_exp_q    <= '0;
      s2_man_q    <= '0;
      s2_rbit_q   <= 1'b0;
      s2_presat_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_man_q   <= '0;
      out_sat_q   <= 1'b0;
    end else if (adv) begin
      s1_vld_q    <= s1_vld_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s1_rnd_q    <= s1_rnd_d;
      s2_vld_q    <= s2_vld_d;
      s2_sign_q   <= s2_sign_d;
      s2_rnd_q    <= s2_rnd_d;
      s2_exp_q    <= s2_exp_d;
      s2_man_q    <= s2_man_d;
      s2_rbit_q   <= s2_rbit_d;
      s2_presat_q <= s2_presat_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_man_q   <= out_man_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // The counter runs off transfers only, so it ignores the pipeline enable.
  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign io.out_valid = out_valid_q;
  assign io.out_sign  = out_sign_q;
  assign io.out_exp   = out_exp_q;
  assign io.out_man   = out_man_q;
  assign io.out_sat   = out_sat_q;
  assign io.sat_count = sat_cnt_q;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Bench for fpcvt_pipe: directed vectors, stalls, reset, counter corner cases, random traffic.
module tb_fpcvt_pipe;

  import fpcvt_pkg::*;

  localparam int IN_W    = 12;
  localparam int EXP_W   = 3;
  localparam int MAN_W   = 4;
  localparam int CNT_W   = 16;
  localparam int E_MAX   = e_max(EXP_W);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpcvt_if #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) bus ();
  fpcvt_if #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(2))     bus_c ();

  fpcvt_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  fpcvt_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(2)) dut_c (
    .clk (clk),
    .rst (rst),
    .io  (bus_c)
  );

  typedef struct {
    logic s;
    int   e;
    int   f;
    logic sat;
    int   acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   cnt_m  = 0;
  bit   exact_lat = 0;
  bit   rnd_done  = 0;

  int   d_in  [12] = '{44, 45, 46, 47, 31, 13, 0, -47, 47, -2048, 2047, 2047};
  bit   d_rm  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
  bit   d_s   [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
  int   d_e   [12] = '{2, 2, 2, 2, 2, 0, 0, 2, 2, 7, 7, 7};
  int   d_f   [12] = '{11, 11, 12, 12, 8, 13, 0, 12, 11, 15, 15, 15};
  bit   d_sat [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
  int   edge_vals [8] = '{0, -2048, 2047, -1, 1, 15, 16, 31};

  exp_t            dir_x;
  logic [IN_W-1:0] rnd_r;
  int              rnd_d;
  bit              rnd_rm;
  exp_t            mon_e;
  fp_t             mon_act;
  fp_t             snap;
  bit              prev_stall = 0;
  bit              xfer_sat;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, req);
    end
  endtask

  // Reference: choose the smallest scale 2^e that fits the magnitude in MAN_W bits,
  // divide with optional half-up rounding, then renormalise and clamp.
  function automatic exp_t model(input int d, input bit rm);
    exp_t x;
    int   m;
    int   e;
    int   f;
    m = (d < 0) ? -d : d;
    e = 0;
    while ((m >> e) >= (1 << MAN_W)) e++;
    if (rm == RND_HALF_UP && e > 0) f = (m + (1 << (e - 1))) >> e;
    else                            f = m >> e;
    if (f == (1 << MAN_W)) begin
      f = 1 << (MAN_W - 1);
      e++;
    end
    x.s   = (d < 0);
    x.sat = (m >= (1 << (MAN_W + E_MAX))) || (e > E_MAX);
    if (x.sat) begin
      e = E_MAX;
      f = (1 << MAN_W) - 1;
    end
    x.e   = e;
    x.f   = f;
    x.acc = 0;
    return x;
  endfunction

  function automatic fp_t to_fp(input exp_t x);
    fp_t r;
    r.sign = x.s;
    r.exp  = DEF_EXP_W'(x.e);
    r.man  = DEF_MAN_W'(x.f);
    r.sat  = x.sat;
    return r;
  endfunction

  task automatic send(input logic [IN_W-1:0] d, input logic rm, input exp_t e);
    int n  = 0;
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.rnd_mode = rm;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      else n++;
    end
    checks++;
    if (ok) begin
      e.acc = cyc;
      exp_q.push_back(e);
    end else begin
      errors++;
      $display("FAIL send_timeout at cycle %0d: in_ready 0, expected 1 within 100 cycles", cyc);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_out_valid(input string nm);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(bus.out_valid), 32'd1);
  endtask

  // Scoreboard monitor: pops on every transfer; also tracks the expected counter.
  always @(negedge clk) begin
    mon_act  = {bus.out_sign, bus.out_exp, bus.out_man, bus.out_sat};
    xfer_sat = 0;
    if (rst) begin
      prev_stall = 0;
      cnt_m      = 0;
    end else begin
      chk("sat_count", 32'(bus.sat_count), 32'(cnt_m));
      if (prev_stall) chk("stall_hold", 32'({bus.out_valid, mon_act}), 32'({1'b1, snap}));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output at cycle %0d: got 0x%0h, expected no output", cyc, mon_act);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", 32'(mon_act), 32'(to_fp(mon_e)));
          if (exact_lat) chk("latency", 32'(cyc - mon_e.acc), 32'd3);
          xfer_sat = mon_e.sat;
        end
      end
      if (bus.sat_clr) cnt_m = 0;
      else if (xfer_sat && cnt_m < CNT_MAX) cnt_m++;
      prev_stall = bus.out_valid && !bus.out_ready;
      snap       = mon_act;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: bench still running, expected completion", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.rnd_mode    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.sat_clr     = 1'b0;
    bus_c.in_valid  = 1'b0;
    bus_c.in_data   = '0;
    bus_c.rnd_mode  = 1'b0;
    bus_c.out_ready = 1'b1;
    bus_c.sat_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_fields", 32'({bus.out_sign, bus.out_exp, bus.out_man, bus.out_sat}), 32'd0);
    chk("rst_sat_count", 32'(bus.sat_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors back-to-back from an empty pipe, fixed expected results.
    exact_lat = 1;
    for (int i = 0; i < 12; i++) begin
      dir_x = '{s: d_s[i], e: d_e[i], f: d_f[i], sat: d_sat[i], acc: 0};
      send(IN_W'(d_in[i]), d_rm[i], dir_x);
    end
    drain();
    exact_lat = 0;
    chk("sat_count_two", 32'(bus.sat_count), 32'd2);

    // Reset with samples in flight.
    send(IN_W'(100), 1'b0, model(100, 1'b0));
    send(IN_W'(-200), 1'b0, model(-200, 1'b0));
    send(IN_W'(2047), 1'b0, model(2047, 1'b0));
    chk("pre_rst_count", 32'(bus.sat_count), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_flush_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_flush_count", 32'(bus.sat_count), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_flush_idle", 32'(bus.out_valid), 32'd0);

    // Backpressure: consumer stalls for 5 cycles from the first result.
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          rnd_d = 300 * i - 700;
          send(IN_W'(rnd_d), 1'b0, model(rnd_d, 1'b0));
        end
      end
      begin
        wait_out_valid("bp_first_valid");
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_inflight", 32'(exp_q.size()), 32'd3);
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Clear collides with a saturated transfer.
    send(IN_W'(2047), 1'b0, model(2047, 1'b0));
    drain();
    chk("pre_clr_count", 32'(bus.sat_count), 32'd1);
    bus.out_ready = 1'b0;
    send(IN_W'(-2048), 1'b0, model(-2048, 1'b0));
    wait_out_valid("clr_valid");
    @(posedge clk);
    #1;
    bus.sat_clr   = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.sat_clr = 1'b0;
    chk("clr_priority", 32'(bus.sat_count), 32'd0);

    // Random traffic with random gaps, stalls and occasional clears.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 7) == 0) rnd_r = IN_W'(edge_vals[$urandom_range(0, 7)]);
          else                           rnd_r = IN_W'($urandom());
          rnd_d  = $signed(rnd_r);
          rnd_rm = 1'($urandom_range(0, 1));
          send(rnd_r, rnd_rm, model(rnd_d, rnd_rm));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
          bus.sat_clr   = ($urandom_range(0, 31) == 0);
        end
        bus.out_ready = 1'b1;
        bus.sat_clr   = 1'b0;
      end
    join
    drain();

    // Narrow counter: five saturated transfers must stick at 3.
    bus_c.in_data  = IN_W'(2047);
    bus_c.rnd_mode = 1'b0;
    bus_c.in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus_c.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("cnt_stick", 32'(bus_c.sat_count), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
